// File: rtl/mips16_muldiv_seq.sv
// Iterative mult/multu/div/divu unit for the 16-bit MIPS core. It owns the HI/LO
// pair and holds fetch while an operation is in flight; each operation takes WIDTH+2 cycles.
module mips16_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_write_en,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero,
    output logic             instr_stall_sl
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               div_zero_q, div_zero_d;

    // Magnitudes of the incoming operands; -0x8000 stays 0x8000 read as unsigned.
    logic             in_neg_a, in_neg_b;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;

    assign in_neg_a = ~op[0] & operand_a[WIDTH-1];
    assign in_neg_b = ~op[0] & operand_b[WIDTH-1];
    assign in_mag_a = in_neg_a ? -operand_a : operand_a;
    assign in_mag_b = in_neg_b ? -operand_b : operand_b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every _d takes its _q first so no path through this block can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (hilo_write_en) begin
                    if (hilo_sel) hi_d = hilo_wdata;
                    else          lo_d = hilo_wdata;
                end
                if (start) begin
                    state_d    = RUN;
                    count_d    = '0;
                    is_div_d   = op[1];
                    neg_a_d    = in_neg_a;
                    neg_b_d    = in_neg_b;
                    a_raw_d    = operand_a;
                    div_zero_d = 1'b0;
                    opnd_d     = op[1] ? in_mag_b : in_mag_a;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
                end
            end
            RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opnd_q == '0) begin
                    hi_d       = a_raw_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge _d values together.
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            a_raw_q    <= a_raw_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi             = hi_q;
    assign lo             = lo_q;
    assign div_zero       = div_zero_q;
    assign busy           = (state_q == RUN) || (state_q == FIX);
    assign ready          = (state_q == DONE);
    assign instr_stall_sl = ((state_q == IDLE) && start) || busy;

endmodule
